irq_ctrl: RTL and testbench
===========================

# irq_ctrl

- Parametrised, sequential interrupt/exception controller for the single-cycle CPU.
- Latches N_SRC external interrupt lines plus the two non-maskable exceptions (ALU overflow, stack overflow) and arbitrates by fixed priority.
- Tracks nested in-service levels and drives the call/return vector selects consumed by the control unit and the PC/stack datapath.
- Replaces purely combinational interrupt selection with pending/in-service registers and a request/acknowledge handshake.

## Interface
Parameters:
- N_SRC, 8, number of maskable interrupt sources (1..29)
- VEC_W, 8, vector width; N_SRC+3 <= 2^VEC_W

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- irq  in  N_SRC  interrupt lines, rising-edge sensitive; bit 0 highest priority
- exc_alu  in  1  ALU overflow, one-cycle pulse, non-maskable
- exc_stack  in  1  stack overflow, one-cycle pulse, non-maskable
- ier_we  in  1  write enable for interrupt-enable register
- ier_din  in  N_SRC  new enable mask
- int_ack  in  1  core accepts the outstanding request this cycle
- reti  in  1  core executing a return-from-interrupt this cycle
- int_req  out  1  interrupt call requested; core must stall its opcode
- s_calli  out  VEC_W  vector of outstanding request, 0 when int_req=0
- s_reti  out  VEC_W  vector being retired, valid in the reti cycle, else 0
- ier  out  N_SRC  current enable register
- isr  out  N_SRC+2  in-service bits {src N_SRC-1..0, stack, alu}, bit 0 = alu

## Operation
- Vectors: exc_alu=1, exc_stack=2, irq[i]=i+3; 0 means none.
- Priority, high to low: alu, stack, irq[0] .. irq[N_SRC-1].
- Pending register pend[N_SRC+1:0]:
  - Set on exc pulse or irq rising edge (irq=1 while registered irq_q=0).
  - Cleared for the accepted source on ack.
  - If set and clear hit the same bit in the same cycle, set wins.
- Eligible = pend & {ier, 2'b11}. Winner = highest-priority eligible bit whose priority is strictly above the highest set isr bit (preemption).
- FSM:
  - IDLE: if a winner exists -> REQ, latching the winner's vector.
  - REQ: int_req=1, s_calli=latched vector. On int_ack -> IDLE; the latched source's isr bit is set and its pend bit cleared.
  - There is no re-arbitration while in REQ, even if a higher-priority source arrives.
- reti:
  - s_reti = vector of the highest-priority set isr bit (combinational); that bit clears at the edge.
  - If isr is empty, s_reti=0 and no state changes.
  - reti is processed in any FSM state.
- reti and int_ack in the same cycle: both take effect. The clear targets the highest isr bit before the ack's set.
- ier_we: ier <= ier_din at the edge. Masking blocks dispatch only, never pending capture.

## Timing
- Reset values: state=IDLE, pend=0, isr=0, ier=0, irq_q=0, int_req=0, s_calli=0, s_reti=0.
- irq rising edge sampled at edge t -> pend set at t -> FSM enters REQ at t+1. int_req is high in the cycle following t+1.
- Exception pulse at edge t behaves identically: 2-edge latency.
- int_req holds until the edge where int_ack=1. int_ack while int_req=0 is ignored.
- After ack, IDLE lasts at least one cycle before the next REQ.
- reset mid-REQ: request dropped, all pending and in-service state lost.

## Configuration
- IRQ_NEST_EN defined: preemption as above, so up to N_SRC+2 nested levels.
- IRQ_NEST_EN undefined:
  - Maskable sources dispatch only when isr is all zero.
  - Exceptions still preempt anything except a higher-or-equal exception in service.

## Test plan
- Enable and priority: reset; ier=8'hFF; irq=8'b0010_0100 rising together -> int_req, s_calli=5; ack; next REQ s_calli=8 only after reti of 5 (nesting disabled) or immediately blocked since 8 is lower priority (nesting enabled) -> s_calli=8 only after s_reti=5.
- Preemption (IRQ_NEST_EN): irq[4] acked (isr[6]=1); irq[1] rises -> int_req, s_calli=4. Two retis -> s_reti=4 then 7.
- Exception: pulse exc_stack while ier=0 -> s_calli=2. Pulse exc_alu while stack is in service -> s_calli=1 (preempts).
- Masking: ier=0, irq[3] rises -> no int_req. Write ier=8'h08 -> int_req within 2 cycles, s_calli=6.
- Boundaries: reti with isr=0 -> s_reti=0, no change. Same-cycle ack+reti leaves the correct isr. Reset asserted during REQ -> int_req=0 next cycle, pend=0.
- Hold: int_ack withheld 10 cycles -> int_req and s_calli stay stable despite a higher-priority arrival.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl -- interrupt / exception controller for the single-cycle CPU.
//
// Captures N_SRC rising-edge interrupt lines plus two non-maskable exception
// pulses (ALU overflow, stack overflow) into a pending register. It then
// arbitrates by fixed priority against the in-service set and raises a
// request that the core acknowledges. It also tracks nested in-service
// levels so that a return-from-interrupt retires the highest-priority
// active level.
//
// Priority / bit order (index 0 highest): alu, stack, irq[0] .. irq[N_SRC-1].
// Vector of bit index k is k+1 (alu=1, stack=2, irq[i]=i+3); 0 means none.
//
// Configuration macro: IRQ_NEST_EN
//   defined   : any eligible source strictly above the highest in-service
//               level may preempt (up to N_SRC+2 nested levels).
//   undefined : maskable sources dispatch only when nothing is in service;
//               exceptions still preempt lower-priority levels.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset      synchronous active-high reset
//   irq        interrupt lines, rising-edge sensitive, bit 0 highest
//   exc_alu    ALU overflow pulse (non-maskable)
//   exc_stack  stack overflow pulse (non-maskable)
//   ier_we     interrupt-enable register write strobe
//   ier_din    new enable mask
//   int_ack    core accepts the outstanding request this cycle
//   reti       core executes return-from-interrupt this cycle
//   int_req    interrupt call requested (core stalls its opcode)
//   s_calli    vector of outstanding request, 0 when int_req=0
//   s_reti     vector being retired in the reti cycle, else 0
//   ier        current enable register
//   isr        in-service bits {src N_SRC-1..0, stack, alu}
module irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int VEC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   irq,
  input  logic               exc_alu,
  input  logic               exc_stack,
  input  logic               ier_we,
  input  logic [N_SRC-1:0]   ier_din,
  input  logic               int_ack,
  input  logic               reti,
  output logic               int_req,
  output logic [VEC_W-1:0]   s_calli,
  output logic [VEC_W-1:0]   s_reti,
  output logic [N_SRC-1:0]   ier,
  output logic [N_SRC+1:0]   isr
);

  localparam int NB = N_SRC + 2;

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   vec_lat, vec_nxt;
  logic [NB-1:0]      pend, pend_nxt, pend_set, pend_clr;
  logic [NB-1:0]      isr_r, isr_nxt, reti_clr;
  logic [NB-1:0]      allowed, cand;
  logic [N_SRC-1:0]   ier_r, irq_q;
  logic [VEC_W-1:0]   win_vec, reti_vec;
  logic               busy;
  logic               ack_take;

  // Vector of the highest-priority (lowest-index) set bit, 0 if none.
  function automatic logic [VEC_W-1:0] first_vec(input logic [NB-1:0] bits);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (bits[i]) v = VEC_W'(i + 1);
    end
    return v;
  endfunction

  // One-hot bit mask selected by a vector; vector 0 gives an empty mask.
  function automatic logic [NB-1:0] vec_onehot(input logic [VEC_W-1:0] v);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      m[i] = (v == VEC_W'(i + 1));
    end
    return m;
  endfunction

  // Arbitration: a candidate must sit strictly above every in-service level.
  always_comb begin
    busy    = 1'b0;
    allowed = '0;
    for (int i = 0; i < NB; i++) begin
      busy       = busy | isr_r[i];
      allowed[i] = ~busy;
    end
`ifndef IRQ_NEST_EN
    // Without nesting, maskable sources wait for a completely idle isr.
    if (|isr_r) allowed[NB-1:2] = '0;
`endif
    cand    = pend & {ier_r, 2'b11} & allowed;
    win_vec = first_vec(cand);
  end

  // Pending / in-service bookkeeping.
  always_comb begin
    ack_take = (state == REQ) && int_ack;
    pend_set = {irq & ~irq_q, exc_stack, exc_alu};
    pend_clr = ack_take ? vec_onehot(vec_lat) : '0;
    // Set wins over the ack clear on the same bit.
    pend_nxt = (pend & ~pend_clr) | pend_set;
    reti_vec = reti ? first_vec(isr_r) : '0;
    reti_clr = vec_onehot(reti_vec);
    // reti retires the level that was highest before this cycle's ack.
    isr_nxt  = (isr_r & ~reti_clr) | pend_clr;
  end

  // Request FSM: no re-arbitration while a request is outstanding.
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_lat;
    case (state)
      IDLE: begin
        if (win_vec != '0) begin
          state_nxt = REQ;
          vec_nxt   = win_vec;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_nxt = IDLE;
          vec_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        vec_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      vec_lat <= '0;
      pend    <= '0;
      isr_r   <= '0;
      ier_r   <= '0;
      irq_q   <= '0;
    end else begin
      state   <= state_nxt;
      vec_lat <= vec_nxt;
      pend    <= pend_nxt;
      isr_r   <= isr_nxt;
      irq_q   <= irq;
      if (ier_we) ier_r <= ier_din;
    end
  end

  assign int_req = (state == REQ);
  assign s_calli = (state == REQ) ? vec_lat : '0;
  assign s_reti  = reti_vec;
  assign ier     = ier_r;
  assign isr     = isr_r;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  localparam int N_SRC = 8;
  localparam int VEC_W = 8;
  localparam int NB    = N_SRC + 2;

  logic             clk;
  logic             reset;
  logic [N_SRC-1:0] irq;
  logic             exc_alu, exc_stack, ier_we, int_ack, reti;
  logic [N_SRC-1:0] ier_din;
  logic             int_req;
  logic [VEC_W-1:0] s_calli, s_reti;
  logic [N_SRC-1:0] ier;
  logic [NB-1:0]    isr;

  int n_tests = 0;
  int n_fail  = 0;

  irq_ctrl #(.N_SRC(N_SRC), .VEC_W(VEC_W)) dut (
    .clk(clk), .reset(reset), .irq(irq), .exc_alu(exc_alu),
    .exc_stack(exc_stack), .ier_we(ier_we), .ier_din(ier_din),
    .int_ack(int_ack), .reti(reti), .int_req(int_req), .s_calli(s_calli),
    .s_reti(s_reti), .ier(ier), .isr(isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending flags per vector, a stack of in-service
  // vectors (newest level on top is always the highest priority), and the
  // outstanding request.
  bit               pend_m [NB];
  int               stk [$];
  bit               inreq_m;
  int               reqv_m;
  logic [N_SRC-1:0] ier_m;
  logic [N_SRC-1:0] irqprev_m;

  function automatic int model_winner();
    int top;
    bit enabled;
    bit ok;
    top = (stk.size() == 0) ? 1000 : stk[$];
    for (int v = 1; v <= NB; v++) begin
      enabled = (v <= 2) ? 1'b1 : ier_m[v-3];
      ok = (v < top);
`ifndef IRQ_NEST_EN
      ok = ok && ((v <= 2) || (stk.size() == 0));
`endif
      if (pend_m[v-1] && enabled && ok) return v;
    end
    return 0;
  endfunction

  function automatic logic [NB-1:0] model_isr();
    logic [NB-1:0] b;
    b = '0;
    foreach (stk[i]) b[stk[i]-1] = 1'b1;
    return b;
  endfunction

  task automatic model_update();
    int  w;
    bit  ack_eff;
    int  acked;
    if (reset) begin
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      stk.delete();
      inreq_m   = 1'b0;
      reqv_m    = 0;
      ier_m     = '0;
      irqprev_m = '0;
    end else begin
      w       = model_winner();
      ack_eff = inreq_m && int_ack;
      acked   = reqv_m;
      if (!inreq_m) begin
        if (w != 0) begin
          inreq_m = 1'b1;
          reqv_m  = w;
        end
      end else if (int_ack) begin
        inreq_m = 1'b0;
        reqv_m  = 0;
      end
      if (reti && stk.size() > 0) void'(stk.pop_back());
      if (ack_eff) begin
        stk.push_back(acked);
        pend_m[acked-1] = 1'b0;
      end
      if (exc_alu)   pend_m[0] = 1'b1;
      if (exc_stack) pend_m[1] = 1'b1;
      for (int i = 0; i < N_SRC; i++)
        if (irq[i] && !irqprev_m[i]) pend_m[i+2] = 1'b1;
      if (ier_we) ier_m = ier_din;
      irqprev_m = irq;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are applied after a falling edge; outputs are compared against
  // the model just before the rising edge, then the model advances.
  task automatic tick();
    int exp_reti;
    #1;
    exp_reti = (reti && stk.size() > 0) ? stk[$] : 0;
    chk("m_int_req", 32'(int_req), 32'(inreq_m));
    chk("m_s_calli", 32'(s_calli), inreq_m ? 32'(reqv_m) : 32'd0);
    chk("m_s_reti",  32'(s_reti),  32'(exp_reti));
    chk("m_isr",     32'(isr),     32'(model_isr()));
    chk("m_ier",     32'(ier),     32'(ier_m));
    @(posedge clk);
    model_update();
    @(negedge clk);
    exc_alu = 1'b0; exc_stack = 1'b0; int_ack = 1'b0; reti = 1'b0; ier_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq = '0; exc_alu = 1'b0; exc_stack = 1'b0;
    ier_we = 1'b0; ier_din = '0; int_ack = 1'b0; reti = 1'b0;
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    inreq_m = 1'b0; reqv_m = 0; ier_m = '0; irqprev_m = '0;
    @(negedge clk);

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_int_req", 32'(int_req), 32'd0);
    chk("rst_isr", 32'(isr), 32'd0);
    chk("rst_ier", 32'(ier), 32'd0);

    // Enable and priority
    ier_we = 1'b1; ier_din = 8'hFF; tick();
    chk("ier_write", 32'(ier), 32'hFF);
    irq = 8'b0010_0100; tick();
    chk("prio_latency", 32'(int_req), 32'd0);
    tick();
    chk("prio_req", 32'(int_req), 32'd1);
    chk("prio_vec5", 32'(s_calli), 32'd5);
    int_ack = 1'b1; tick();
    chk("prio_ack_req", 32'(int_req), 32'd0);
    chk("prio_isr", 32'(isr), 32'h010);
    tick(); tick();
    chk("prio_blocked", 32'(int_req), 32'd0);
    reti = 1'b1; #1;
    chk("prio_reti5", 32'(s_reti), 32'd5);
    tick();
    chk("prio_isr_clr", 32'(isr), 32'd0);
    tick();
    chk("prio_vec8", 32'(s_calli), 32'd8);
    int_ack = 1'b1; tick();
    reti = 1'b1; #1;
    chk("prio_reti8", 32'(s_reti), 32'd8);
    tick();

    // Exceptions ignore the enable mask; alu preempts stack
    ier_we = 1'b1; ier_din = 8'h00; tick();
    exc_stack = 1'b1; tick(); tick();
    chk("exc_stack_vec", 32'(s_calli), 32'd2);
    int_ack = 1'b1; tick();
    chk("exc_stack_isr", 32'(isr), 32'h002);
    exc_alu = 1'b1; tick(); tick();
    chk("exc_alu_vec", 32'(s_calli), 32'd1);
    int_ack = 1'b1; tick();
    chk("exc_both_isr", 32'(isr), 32'h003);
    reti = 1'b1; #1;
    chk("exc_reti1", 32'(s_reti), 32'd1);
    tick();
    reti = 1'b1; #1;
    chk("exc_reti2", 32'(s_reti), 32'd2);
    tick();
    chk("exc_isr_empty", 32'(isr), 32'd0);

    // Masking blocks dispatch but not capture
    irq = 8'h00; tick();
    irq = 8'b0000_1000; tick(); tick(); tick();
    chk("mask_no_req", 32'(int_req), 32'd0);
    ier_we = 1'b1; ier_din = 8'h08; tick(); tick();
    chk("mask_req", 32'(int_req), 32'd1);
    chk("mask_vec6", 32'(s_calli), 32'd6);
    int_ack = 1'b1; tick();
    reti = 1'b1; tick();

    // Preemption by a higher-priority line
    ier_we = 1'b1; ier_din = 8'hFF; irq = 8'h10; tick(); tick();
    chk("pre_vec7", 32'(s_calli), 32'd7);
    int_ack = 1'b1; tick();
    chk("pre_isr7", 32'(isr), 32'h040);
    irq = 8'h12; tick(); tick();
`ifdef IRQ_NEST_EN
    chk("pre_req", 32'(int_req), 32'd1);
    chk("pre_vec4", 32'(s_calli), 32'd4);
    int_ack = 1'b1; tick();
    chk("pre_isr_nest", 32'(isr), 32'h048);
    reti = 1'b1; #1;
    chk("pre_reti4", 32'(s_reti), 32'd4);
    tick();
    reti = 1'b1; #1;
    chk("pre_reti7", 32'(s_reti), 32'd7);
    tick();
`else
    chk("pre_nonest_block", 32'(int_req), 32'd0);
    reti = 1'b1; #1;
    chk("pre_reti7", 32'(s_reti), 32'd7);
    tick(); tick();
    chk("pre_vec4", 32'(s_calli), 32'd4);
    int_ack = 1'b1; tick();
    reti = 1'b1; tick();
`endif
    chk("pre_isr_empty", 32'(isr), 32'd0);

    // reti with nothing in service
    irq = 8'h00; tick();
    reti = 1'b1; #1;
    chk("reti_empty", 32'(s_reti), 32'd0);
    tick();
    chk("reti_empty_isr", 32'(isr), 32'd0);

    // Same-cycle ack and reti
    irq = 8'h10; tick(); tick();
    int_ack = 1'b1; tick();
    exc_stack = 1'b1; tick(); tick();
    chk("ackreti_vec2", 32'(s_calli), 32'd2);
    int_ack = 1'b1; reti = 1'b1; #1;
    chk("ackreti_sreti", 32'(s_reti), 32'd7);
    tick();
    chk("ackreti_isr", 32'(isr), 32'h002);
    chk("ackreti_req", 32'(int_req), 32'd0);
    reti = 1'b1; tick();

    // Reset during a request
    irq = 8'h00; exc_alu = 1'b1; tick(); tick();
    chk("rstreq_req", 32'(int_req), 32'd1);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("rstreq_drop", 32'(int_req), 32'd0);
    tick(); tick();
    chk("rstreq_nopend", 32'(int_req), 32'd0);

    // Request holds while ack is withheld, despite a higher arrival
    ier_we = 1'b1; ier_din = 8'hFF; irq = 8'h80; tick(); tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) exc_alu = 1'b1;
      tick();
      chk("hold_req", 32'(int_req), 32'd1);
      chk("hold_vec10", 32'(s_calli), 32'd10);
    end
    int_ack = 1'b1; tick();
    chk("hold_gap", 32'(int_req), 32'd0);
    tick();
    chk("hold_next_alu", 32'(s_calli), 32'd1);
    int_ack = 1'b1; tick();
    reti = 1'b1; tick();
    reti = 1'b1; tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) irq = irq ^ N_SRC'(1 << $urandom_range(0, N_SRC-1));
      exc_alu   = ($urandom_range(0, 15) == 0);
      exc_stack = ($urandom_range(0, 15) == 0);
      ier_we    = ($urandom_range(0, 19) == 0);
      ier_din   = N_SRC'($urandom);
      int_ack   = ($urandom_range(0, 2) == 0);
      reti      = ($urandom_range(0, 4) == 0);
      reset     = ($urandom_range(0, 399) == 0);
      tick();
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
